// File: rtl/nnet_frame_sequencer.sv
// Admits one inference frame at a time into the HLS core, pads short frames,
// regenerates tlast on the result stream and aborts inferences that stall in DRAIN.
module nnet_frame_sequencer #(
    parameter logic [7:0]  SR_NNET_CTRL    = 8'd132,
    parameter logic [7:0]  SR_NNET_TIMEOUT = 8'd133,
    parameter logic [23:0] TIMEOUT_RST     = 24'd65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [15:0] size_in,
    input  logic [15:0] size_out,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_nn_tdata,
    output logic        m_nn_tvalid,
    input  logic        m_nn_tready,
    input  logic [31:0] s_nn_tdata,
    input  logic        s_nn_tvalid,
    output logic        s_nn_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] frame_count,
    output logic [15:0] err_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        PAD   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t      state_r;
    state_t      state_s;

    logic        enable_r;
    logic        pad_en_r;
    logic [23:0] timeout_r;

    logic [15:0] size_in_r;
    logic [15:0] size_out_r;
    logic [15:0] in_cnt_r;
    logic [15:0] out_cnt_r;
    logic [23:0] stall_cnt_r;
    logic [31:0] frame_count_r;
    logic [15:0] err_count_r;

    logic        start_s;
    logic        in_hs_s;
    logic        pad_hs_s;
    logic        out_hs_s;
    logic        in_last_s;
    logic        pad_done_s;
    logic        out_last_s;
    logic        short_s;
    logic [23:0] stall_next_s;
    logic        timeout_hit_s;

    assign start_s       = (state_r == IDLE) && enable_r &&
                           (size_in != 16'd0) && (size_out != 16'd0);
    assign in_hs_s       = (state_r == FEED) && s_axis_tvalid && m_nn_tready;
    assign pad_hs_s      = (state_r == PAD) && m_nn_tready;
    assign out_hs_s      = (state_r == DRAIN) && s_nn_tvalid && m_axis_tready;
    assign in_last_s     = (in_cnt_r == (size_in_r - 16'd1));
    assign pad_done_s    = ((in_cnt_r + 16'd1) == size_in_r);
    assign out_last_s    = (out_cnt_r == (size_out_r - 16'd1));
    assign short_s       = in_hs_s && s_axis_tlast && !in_last_s && pad_en_r;
    assign stall_next_s  = stall_cnt_r + 24'd1;
    // A result handshake in the same cycle always beats the timeout.
    assign timeout_hit_s = (state_r == DRAIN) && !out_hs_s &&
                           (timeout_r != 24'd0) && (stall_next_s == timeout_r);

    // Settings registers; only the hard reset restores their defaults.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r  <= 1'b0;
            pad_en_r  <= 1'b1;
            timeout_r <= TIMEOUT_RST;
        end else if (set_stb && (set_addr == SR_NNET_CTRL)) begin
            enable_r  <= set_data[0];
            pad_en_r  <= set_data[1];
        end else if (set_stb && (set_addr == SR_NNET_TIMEOUT)) begin
            timeout_r <= set_data[23:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = FEED;
                end else begin
                    state_s = IDLE;
                end
            end
            FEED: begin
                if (in_hs_s && in_last_s) begin
                    state_s = DRAIN;
                end else if (short_s) begin
                    state_s = PAD;
                end else begin
                    state_s = FEED;
                end
            end
            PAD: begin
                if (pad_hs_s && pad_done_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = PAD;
                end
            end
            DRAIN: begin
                if (out_hs_s && out_last_s) begin
                    state_s = IDLE;
                end else if (timeout_hit_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM outputs: combinational pass-through in FEED and DRAIN, zero fill in PAD.
    always_comb begin
        s_axis_tready = 1'b0;
        m_nn_tdata    = 32'd0;
        m_nn_tvalid   = 1'b0;
        s_nn_tready   = 1'b0;
        m_axis_tdata  = 32'd0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_r)
            FEED: begin
                m_nn_tdata    = s_axis_tdata;
                m_nn_tvalid   = s_axis_tvalid;
                s_axis_tready = m_nn_tready;
            end
            PAD: begin
                m_nn_tvalid   = 1'b1;
            end
            DRAIN: begin
                s_nn_tready   = m_axis_tready;
                m_axis_tvalid = s_nn_tvalid;
                m_axis_tdata  = s_nn_tdata;
                m_axis_tlast  = out_last_s;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    // Frame sizes are frozen at frame start so mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            size_in_r  <= 16'd0;
            size_out_r <= 16'd0;
        end else if (start_s) begin
            size_in_r  <= size_in;
            size_out_r <= size_out;
        end
    end

    // Word counters for the input frame and the result frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            in_cnt_r  <= 16'd0;
            out_cnt_r <= 16'd0;
        end else if (start_s) begin
            in_cnt_r  <= 16'd0;
            out_cnt_r <= 16'd0;
        end else begin
            if (in_hs_s || pad_hs_s) begin
                in_cnt_r <= in_cnt_r + 16'd1;
            end
            if (out_hs_s) begin
                out_cnt_r <= out_cnt_r + 16'd1;
            end
        end
    end

    // Stall counter: DRAIN cycles since the last result handshake.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            stall_cnt_r <= 24'd0;
        end else if (start_s || out_hs_s) begin
            stall_cnt_r <= 24'd0;
        end else if (state_r == DRAIN) begin
            stall_cnt_r <= stall_next_s;
        end
    end

    // Completed-frame and error counters exported for readback.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_count_r <= 32'd0;
            err_count_r   <= 16'd0;
        end else begin
            if (out_hs_s && out_last_s) begin
                frame_count_r <= frame_count_r + 32'd1;
            end
            if (short_s || timeout_hit_s) begin
                err_count_r <= sat_inc16(err_count_r);
            end
        end
    end

    assign frame_count = frame_count_r;
    assign err_count   = err_count_r;
    assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_nnet_frame_sequencer.sv
// Directed bench for nnet_frame_sequencer; the bench plays both the wrapper
// and the HLS core and checks streams and counters against hand-computed values.
module tb_nnet_frame_sequencer;

    localparam logic [7:0] CTRL_ADDR = 8'd132;
    localparam logic [7:0] TMO_ADDR  = 8'd133;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [15:0] size_in = 16'd0;
    logic [15:0] size_out = 16'd0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_nn_tdata;
    logic        m_nn_tvalid;
    logic        m_nn_tready = 1'b0;
    logic [31:0] s_nn_tdata = 32'd0;
    logic        s_nn_tvalid = 1'b0;
    logic        s_nn_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] frame_count;
    logic [15:0] err_count;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] core_in[$];
    logic [32:0] out_q[$];
    bit drain_watch = 1'b0;
    int drain_viol  = 0;

    nnet_frame_sequencer dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .size_in(size_in), .size_out(size_out),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_nn_tdata(m_nn_tdata), .m_nn_tvalid(m_nn_tvalid), .m_nn_tready(m_nn_tready),
        .s_nn_tdata(s_nn_tdata), .s_nn_tvalid(s_nn_tvalid), .s_nn_tready(s_nn_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .frame_count(frame_count), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitors sample on the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (m_nn_tvalid && m_nn_tready) core_in.push_back(m_nn_tdata);
        if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
        if (drain_watch && s_axis_tready) drain_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic setup(input logic [15:0] si, input logic [15:0] so, input logic [31:0] ctrl);
        write_reg(CTRL_ADDR, 32'd0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        size_in = si; size_out = so;
        core_in.delete(); out_q.delete();
        write_reg(CTRL_ADDR, ctrl);
    endtask

    task automatic push_in(input logic [31:0] d, input bit last, input bit rnd);
        bit done = 1'b0;
        s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            m_nn_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_axis_tready) done = 1'b1;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_nn_tready = 1'b1;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL push_in: word %h never accepted", d); end
    endtask

    task automatic push_res(input logic [31:0] d, input bit rnd);
        bit done = 1'b0;
        s_nn_tdata = d; s_nn_tvalid = 1'b1;
        for (int i = 0; i < 500 && !done; i++) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (s_nn_tready && m_axis_tready) done = 1'b1;
            @(posedge clk); #1;
        end
        s_nn_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL push_res: result %h never accepted", d); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b1; m_nn_tready = 1'b1; s_nn_tvalid = 1'b1; m_axis_tready = 1'b1;
        size_in = 16'd4; size_out = 16'd2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_errs: got %0d want 0", err_count); end
        n_checks++;
        if ({s_axis_tready, m_nn_tvalid, s_nn_tready, m_axis_tvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 0000",
                               {s_axis_tready, m_nn_tvalid, s_nn_tready, m_axis_tvalid});
        end
        s_axis_tvalid = 1'b0; s_nn_tvalid = 1'b0;
    endtask

    task automatic test_basic();
        setup(16'd4, 16'd2, 32'd3);
        for (int k = 1; k <= 4; k++) push_in(32'(k), 1'b0, 1'b0);
        s_axis_tdata = 32'd5; s_axis_tvalid = 1'b1; drain_watch = 1'b1;
        push_res(32'hA0, 1'b0); push_res(32'hA1, 1'b0);
        drain_watch = 1'b0;
        for (int k = 5; k <= 8; k++) push_in(32'(k), k == 8, 1'b0);
        drain_watch = 1'b1;
        push_res(32'hA2, 1'b0); push_res(32'hA3, 1'b0);
        drain_watch = 1'b0;
        n_checks++; if (core_in.size() != 8) begin n_fail++; $display("FAIL basic_in_count: got %0d want 8", core_in.size()); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (core_in[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL basic_in[%0d]: got %h want %h", i, core_in[i], i + 1); end
        end
        n_checks++;
        if (out_q.size() != 4 || out_q[0] !== {1'b0, 32'hA0} || out_q[1] !== {1'b1, 32'hA1} ||
            out_q[2] !== {1'b0, 32'hA2} || out_q[3] !== {1'b1, 32'hA3}) begin
            n_fail++; $display("FAIL basic_out: got %0d words (%h %h %h %h) want A0,A1+last,A2,A3+last",
                               out_q.size(), out_q[0], out_q[1], out_q[2], out_q[3]);
        end
        n_checks++; if (frame_count !== 32'd2) begin n_fail++; $display("FAIL basic_frames: got %0d want 2", frame_count); end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL basic_errs: got %0d want 0", err_count); end
        n_checks++; if (drain_viol != 0) begin n_fail++; $display("FAIL basic_drain_ready: %0d cycles ready in DRAIN want 0", drain_viol); end
    endtask

    task automatic test_pad();
        setup(16'd4, 16'd2, 32'd3);
        push_in(32'd10, 1'b0, 1'b0); push_in(32'd11, 1'b1, 1'b0);
        push_res(32'hB0, 1'b0); push_res(32'hB1, 1'b0);
        n_checks++;
        if (core_in.size() != 4 || core_in[0] !== 32'd10 || core_in[1] !== 32'd11 ||
            core_in[2] !== 32'd0 || core_in[3] !== 32'd0) begin
            n_fail++; $display("FAIL pad_core_in: got %0d words %h %h %h %h want 10,11,0,0",
                               core_in.size(), core_in[0], core_in[1], core_in[2], core_in[3]);
        end
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL pad_errs: got %0d want 1", err_count); end
        n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL pad_frames: got %0d want 1", frame_count); end
        n_checks++; if (out_q.size() != 2 || out_q[1] !== {1'b1, 32'hB1}) begin n_fail++; $display("FAIL pad_out: got %0d words last=%h want B1 with tlast", out_q.size(), out_q[1]); end
        // pad_en=0: a short packet leaves the frame open.
        setup(16'd4, 16'd2, 32'd1);
        push_in(32'd20, 1'b0, 1'b0); push_in(32'd21, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL nopad_still_feed: ready got %b want 1", s_axis_tready); end
        @(posedge clk); #1;
        push_in(32'd22, 1'b0, 1'b0); push_in(32'd23, 1'b0, 1'b0);
        push_res(32'hB2, 1'b0); push_res(32'hB3, 1'b0);
        n_checks++;
        if (core_in.size() != 4 || core_in[2] !== 32'd22 || core_in[3] !== 32'd23) begin
            n_fail++; $display("FAIL nopad_core_in: got %0d words, [2]=%h [3]=%h want 22,23", core_in.size(), core_in[2], core_in[3]);
        end
        n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL nopad_errs: got %0d want 0", err_count); end
        n_checks++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL nopad_frames: got %0d want 1", frame_count); end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        bit dropped = 1'b0;
        write_reg(TMO_ADDR, 32'd100);
        setup(16'd4, 16'd2, 32'd3);
        for (int k = 0; k < 4; k++) push_in(32'(32'h30 + k), 1'b0, 1'b0);
        for (int i = 0; i < 300 && !dropped; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) dropped = 1'b1;
        end
        n_checks++; if (!dropped || cyc != 100) begin n_fail++; $display("FAIL timeout_cycles: busy dropped after %0d cycles (dropped=%b) want 100", cyc, dropped); end
        n_checks++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL timeout_errs: got %0d want 1", err_count); end
        n_checks++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL timeout_frames: got %0d want 0", frame_count); end
        n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL timeout_out: got %0d words want 0", out_q.size()); end
    endtask

    task automatic test_backpressure();
        int bad_in = 0;
        int bad_out = 0;
        int n_last = 0;
        setup(16'd16, 16'd5, 32'd3);
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 16; k++) push_in(32'(f * 16 + k), k == 15, 1'b1);
            for (int r = 0; r < 5; r++) push_res(32'hC000_0000 + 32'(f * 5 + r), 1'b1);
        end
        for (int i = 0; i < core_in.size(); i++) if (core_in[i] !== 32'(i)) bad_in++;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i][31:0] !== 32'hC000_0000 + 32'(i)) bad_out++;
            if (out_q[i][32] !== ((i % 5) == 4)) bad_out++;
            if (out_q[i][32] === 1'b1) n_last++;
        end
        n_checks++; if (core_in.size() != 320 || bad_in != 0) begin n_fail++; $display("FAIL bp_in_order: %0d words, %0d out of order, want 320 in order", core_in.size(), bad_in); end
        n_checks++; if (out_q.size() != 100 || bad_out != 0) begin n_fail++; $display("FAIL bp_out_order: %0d words, %0d wrong, want 100 correct", out_q.size(), bad_out); end
        n_checks++; if (n_last != 20) begin n_fail++; $display("FAIL bp_tlast_count: got %0d want 20", n_last); end
        n_checks++; if (frame_count !== 32'd20) begin n_fail++; $display("FAIL bp_frames: got %0d want 20", frame_count); end
    endtask

    task automatic test_size_change();
        setup(16'd4, 16'd2, 32'd3);
        push_in(32'd30, 1'b0, 1'b0);
        size_in = 16'd8;
        for (int k = 1; k < 4; k++) push_in(32'(30 + k), 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (s_axis_tready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL size_old_frame: ready=%b busy=%b want 0/1 after 4 words", s_axis_tready, busy); end
        @(posedge clk); #1;
        push_res(32'hD0, 1'b0); push_res(32'hD1, 1'b0);
        for (int k = 0; k < 7; k++) push_in(32'(40 + k), 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL size_new_open: ready got %b want 1 after 7 of 8 words", s_axis_tready); end
        @(posedge clk); #1;
        push_in(32'd47, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL size_new_closed: ready got %b want 0 after 8 words", s_axis_tready); end
        @(posedge clk); #1;
        push_res(32'hD2, 1'b0); push_res(32'hD3, 1'b0);
        n_checks++; if (frame_count !== 32'd2 || core_in.size() != 12) begin n_fail++; $display("FAIL size_frames: frames=%0d words=%0d want 2/12", frame_count, core_in.size()); end
    endtask

    task automatic test_clear();
        int cyc = 0;
        bit dropped = 1'b0;
        write_reg(TMO_ADDR, 32'd20);
        setup(16'd4, 16'd2, 32'd3);
        push_in(32'd50, 1'b1, 1'b0);
        push_res(32'hE0, 1'b0); push_res(32'hE1, 1'b0);
        n_checks++; if (frame_count !== 32'd1 || err_count !== 16'd1) begin n_fail++; $display("FAIL clear_pre: frames=%0d errs=%0d want 1/1", frame_count, err_count); end
        for (int k = 0; k < 4; k++) push_in(32'(60 + k), 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        s_axis_tvalid = 1'b1; m_nn_tready = 1'b1; s_nn_tvalid = 1'b1; m_axis_tready = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b want 0", busy); end
        n_checks++; if (frame_count !== 32'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL clear_counts: frames=%0d errs=%0d want 0/0", frame_count, err_count); end
        n_checks++;
        if ({s_axis_tready, m_nn_tvalid, s_nn_tready, m_axis_tvalid} !== 4'b0000) begin
            n_fail++; $display("FAIL clear_handshake: got %b want 0000",
                               {s_axis_tready, m_nn_tvalid, s_nn_tready, m_axis_tvalid});
        end
        s_axis_tvalid = 1'b0; s_nn_tvalid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_enable_kept: busy got %b want 1", busy); end
        for (int k = 0; k < 4; k++) push_in(32'(70 + k), 1'b0, 1'b0);
        for (int i = 0; i < 100 && !dropped; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy) dropped = 1'b1;
        end
        n_checks++; if (!dropped || cyc != 20) begin n_fail++; $display("FAIL clear_timeout_kept: dropped after %0d cycles (dropped=%b) want 20", cyc, dropped); end
        n_checks++; if (err_count !== 16'd1 || frame_count !== 32'd0) begin n_fail++; $display("FAIL clear_post_counts: errs=%0d frames=%0d want 1/0", err_count, frame_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_timeout();
        test_backpressure();
        test_size_change();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
